rot_apb_regbank: RTL
====================

Name: rot_apb_regbank

Overview:
- Parametrised APB3 register slave for the rotate engine. Successor to the single-channel rotate APB interface.
- Holds NUM_CH independent rotate channel register sets: DMA source/destination, image size, mode/direction, control and status.
- Adds configurable wait states, byte strobes, PSLVERR, a config lock while busy, a sticky done flag and a masked interrupt.
- Sits between the APB fabric and NUM_CH rotate cores/DMA engines.

Parameters:
NUM_CH, 2, number of rotate channels (1..8)
ADDR_W, 12, APB address width; channel index = I_PADDR[ADDR_W-1:5]
WAIT_STATES, 0, PREADY-low cycles inserted in every access phase (0..3)

Ports:
I_PCLK  in  1  APB clock, single clock domain
I_PRESET  in  1  synchronous active-high reset
I_PSEL  in  1  slave select
I_PENABLE  in  1  access phase
I_PWRITE  in  1  1=write
I_PADDR  in  ADDR_W  byte address, word aligned
I_PWDATA  in  32  write data
I_PSTRB  in  4  byte write enables
O_PRDATA  out  32  read data, valid when O_PREADY=1, else 0
O_PREADY  out  1  transfer complete
O_PSLVERR  out  1  error, valid only with O_PREADY=1
I_CORE_BUSY  in  NUM_CH  per-channel core busy
I_CORE_DONE  in  NUM_CH  per-channel one-cycle done pulse
I_ROT_IMG_NEW_H  in  NUM_CH*16  core-computed output height
I_ROT_IMG_NEW_W  in  NUM_CH*16  core-computed output width
O_DMA_SRC_IMG  out  NUM_CH*32  source base address
O_DMA_DST_IMG  out  NUM_CH*32  destination base address
O_ROT_IMG_H  out  NUM_CH*16  input height
O_ROT_IMG_W  out  NUM_CH*16  input width
O_ROT_IMG_MODE  out  NUM_CH*2  rotate mode
O_ROT_IMG_DIR  out  NUM_CH  rotate direction
O_CTRL_START  out  NUM_CH  one-cycle start pulse
O_CTRL_RESET  out  NUM_CH  one-cycle soft-reset pulse
O_INTR  out  1  OR over channels of done & ~intr_mask

Behaviour:
- Per-channel map, stride 0x20:
  - 0x00 SRC RW
  - 0x04 DST RW
  - 0x08 SIZE RW {H[31:16],W[15:0]}
  - 0x0C NEW_SIZE RO {NEW_H,NEW_W}
  - 0x10 CFG RW {dir[2],mode[1:0]}
  - 0x14 CTRL {intr_mask[2] RW, reset[1] WO, start[0] WO}; reads return only mask
  - 0x18 STATUS {done[1] W1C, busy[0] RO}
  - 0x1C reserved
- Reset: all registers, outputs and the wait counter are 0. O_PREADY=0, O_PSLVERR=0, O_INTR=0.
- Access phase is I_PSEL & I_PENABLE.
  - The wait counter wcnt increments each access-phase cycle while < WAIT_STATES. It clears when the access phase ends or completes.
  - O_PREADY = access & (wcnt==WAIT_STATES), combinational. With WAIT_STATES=0 the transfer completes in the first access cycle.
  - A write commits on the O_PREADY=1 edge only, never in the setup phase.
  - A setup phase alone (PSEL=1, PENABLE=0) has no effect.
- Byte strobes: RW bytes update only where I_PSTRB[i]=1. CTRL and STATUS act only if I_PSTRB[0]=1.
- O_PSLVERR=1 (with O_PREADY) and no state change for any of:
  - channel index >= NUM_CH
  - offset 0x1C
  - write to NEW_SIZE
  - write to SRC/DST/SIZE/CFG while I_CORE_BUSY[ch]=1 (config lock)
  - start=1 while busy
- Reads of error addresses return 0.
- Start/reset control:
  - A committed CTRL write with start=1 and not busy gives O_CTRL_START[ch]=1 for exactly the next cycle.
  - reset=1 gives O_CTRL_RESET[ch]=1 for the next cycle and clears done[ch]. It is accepted even when busy.
  - If start=1 and reset=1 are written together, reset wins and no start pulse is issued.
- Done flag:
  - done[ch] is set by I_CORE_DONE[ch] and cleared by writing 1 to STATUS bit1.
  - A set and clear in the same cycle leaves done=1.
- O_INTR is registered, so it follows done/mask by 1 cycle.
- I_PRESET asserted mid-transfer aborts it: O_PREADY=0 the next cycle and no write commits. The master must reissue the transfer.
- Back-to-back transfers (new setup phase immediately after completion) need no idle cycle.

Decomposition:
- Package rot_apb_pkg:
  - register offset constants, CH_STRIDE=0x20
  - CFG/CTRL/STATUS field bit positions
  - mode encodings: 0=90, 1=180, 2=270, 3=flip
- Sub-module rot_apb_chan_regs: one channel's registers, lock, pulses and done flag. Generated NUM_CH times.
- Top level owns the APB wait counter, address decode, read mux, PSLVERR and the interrupt OR.

Test Plan:
- WAIT_STATES=2; write ch0 SRC=0x1000_0000 -> PREADY low for 2 access cycles, high on the 3rd; readback 0x1000_0000, PSLVERR=0.
- Write ch1 SIZE=0x0040_0080 with PSTRB=4'b0011 -> ch1 O_ROT_IMG_H=0, O_ROT_IMG_W=0x0080; ch0 unchanged.
- Hold I_CORE_BUSY[0]=1; write CFG=3 and CTRL start=1 -> both PSLVERR=1, mode stays 0, no START pulse. Drop busy and retry start -> exactly one START pulse.
- Pulse I_CORE_DONE[1] with mask=0 -> STATUS reads 0x2 and O_INTR=1 next cycle. Write STATUS=0x2 -> O_INTR=0. Repeat with mask=1 -> O_INTR stays 0.
- NUM_CH=2; access addresses 0x040 and 0x01C -> PSLVERR=1, PRDATA=0.
- Assert I_PRESET during the wait state of a write DST=0xABCD -> DST reads 0 after reset, PREADY=0 during reset.

Source files
------------

// File: rtl/rot_apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rot_apb_pkg
// Description : Register map, field positions and mode encodings shared by
//               the rotate-engine APB register bank.
// Revision    : 1.0 - initial release
// ============================================================================
package rot_apb_pkg;

    localparam logic [4:0] OFF_SRC      = 5'h00;
    localparam logic [4:0] OFF_DST      = 5'h04;
    localparam logic [4:0] OFF_SIZE     = 5'h08;
    localparam logic [4:0] OFF_NEW_SIZE = 5'h0C;
    localparam logic [4:0] OFF_CFG      = 5'h10;
    localparam logic [4:0] OFF_CTRL     = 5'h14;
    localparam logic [4:0] OFF_STATUS   = 5'h18;
    localparam logic [4:0] OFF_RSVD     = 5'h1C;

    localparam int CH_STRIDE       = 32'h20;

    localparam int CFG_DIR_BIT     = 2;
    localparam int CTRL_MASK_BIT   = 2;
    localparam int CTRL_RESET_BIT  = 1;
    localparam int CTRL_START_BIT  = 0;
    localparam int STATUS_DONE_BIT = 1;
    localparam int STATUS_BUSY_BIT = 0;

    typedef enum logic [1:0] {
        MODE_90   = 2'd0,
        MODE_180  = 2'd1,
        MODE_270  = 2'd2,
        MODE_FLIP = 2'd3
    } rot_mode_e;

    // Byte-lane merge of write data into an existing register value.
    function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rot_apb_chan_regs.sv
`default_nettype none
// ============================================================================
// Module      : rot_apb_chan_regs
// Description : One rotate channel: config registers, busy lock, start/reset
//               pulses and the sticky done flag.
// Revision    : 1.0 - initial release
// ============================================================================
module rot_apb_chan_regs
    import rot_apb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wr,
    input  logic        i_write,
    input  logic [2:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_strb,
    input  logic        i_busy,
    input  logic        i_done,
    input  logic [15:0] i_new_h,
    input  logic [15:0] i_new_w,
    output logic [31:0] o_rdata,
    output logic        o_err,
    output logic [31:0] o_src,
    output logic [31:0] o_dst,
    output logic [15:0] o_h,
    output logic [15:0] o_w,
    output logic [1:0]  o_mode,
    output logic        o_dir,
    output logic        o_start,
    output logic        o_reset,
    output logic        o_done,
    output logic        o_mask
);

    logic [31:0] r_src_q;
    logic [31:0] r_dst_q;
    logic [31:0] r_size_q;
    rot_mode_e   r_mode_q;
    logic        r_dir_q;
    logic        r_mask_q;
    logic        r_done_q;
    logic        r_start_q;
    logic        r_reset_q;

    logic [4:0]  w_off;
    logic        w_ctrl_wr;
    logic        w_start_d;
    logic        w_reset_d;
    logic        w_done_clr;
    logic        w_cfg_reg;

    assign w_off      = {i_off, 2'b00};
    assign w_ctrl_wr  = i_wr & (w_off == OFF_CTRL) & i_strb[0];
    // Reset has priority: a combined start+reset write only resets.
    assign w_start_d  = w_ctrl_wr & i_wdata[CTRL_START_BIT] & ~i_wdata[CTRL_RESET_BIT];
    assign w_reset_d  = w_ctrl_wr & i_wdata[CTRL_RESET_BIT];
    assign w_done_clr = w_reset_d |
                        (i_wr & (w_off == OFF_STATUS) & i_strb[0] & i_wdata[STATUS_DONE_BIT]);
    assign w_cfg_reg  = (w_off == OFF_SRC) | (w_off == OFF_DST) |
                        (w_off == OFF_SIZE) | (w_off == OFF_CFG);

    always_comb begin
        o_err = 1'b0;
        if (w_off == OFF_RSVD)                             o_err = 1'b1;
        if (i_write && (w_off == OFF_NEW_SIZE))            o_err = 1'b1;
        if (i_write && i_busy && w_cfg_reg)                o_err = 1'b1;
        if (i_write && i_busy && (w_off == OFF_CTRL) && i_strb[0] &&
            i_wdata[CTRL_START_BIT] && !i_wdata[CTRL_RESET_BIT]) o_err = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_src_q   <= '0;
            r_dst_q   <= '0;
            r_size_q  <= '0;
            r_mode_q  <= MODE_90;
            r_dir_q   <= 1'b0;
            r_mask_q  <= 1'b0;
            r_done_q  <= 1'b0;
            r_start_q <= 1'b0;
            r_reset_q <= 1'b0;
        end else begin
            r_start_q <= w_start_d;
            r_reset_q <= w_reset_d;
            // A core done in the same cycle as a clear keeps the flag set.
            if (i_done)          r_done_q <= 1'b1;
            else if (w_done_clr) r_done_q <= 1'b0;
            if (i_wr) begin
                case (w_off)
                    OFF_SRC:  r_src_q  <= strb_merge(r_src_q,  i_wdata, i_strb);
                    OFF_DST:  r_dst_q  <= strb_merge(r_dst_q,  i_wdata, i_strb);
                    OFF_SIZE: r_size_q <= strb_merge(r_size_q, i_wdata, i_strb);
                    OFF_CFG: begin
                        if (i_strb[0]) begin
                            r_dir_q  <= i_wdata[CFG_DIR_BIT];
                            r_mode_q <= rot_mode_e'(i_wdata[1:0]);
                        end
                    end
                    OFF_CTRL: begin
                        if (i_strb[0]) r_mask_q <= i_wdata[CTRL_MASK_BIT];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        o_rdata = '0;
        case (w_off)
            OFF_SRC:      o_rdata = r_src_q;
            OFF_DST:      o_rdata = r_dst_q;
            OFF_SIZE:     o_rdata = r_size_q;
            OFF_NEW_SIZE: o_rdata = {i_new_h, i_new_w};
            OFF_CFG:      o_rdata = {29'd0, r_dir_q, r_mode_q};
            OFF_CTRL:     o_rdata = {29'd0, r_mask_q, 2'b00};
            OFF_STATUS:   o_rdata = {30'd0, r_done_q, i_busy};
            default:      o_rdata = '0;
        endcase
    end

    assign o_src   = r_src_q;
    assign o_dst   = r_dst_q;
    assign o_h     = r_size_q[31:16];
    assign o_w     = r_size_q[15:0];
    assign o_mode  = r_mode_q;
    assign o_dir   = r_dir_q;
    assign o_start = r_start_q;
    assign o_reset = r_reset_q;
    assign o_done  = r_done_q;
    assign o_mask  = r_mask_q;

endmodule
`default_nettype wire

// File: rtl/rot_apb_regbank.sv
`default_nettype none
// ============================================================================
// Module      : rot_apb_regbank
// Description : APB3 register slave for NUM_CH rotate channels with wait
//               states, byte strobes, PSLVERR and a masked interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module rot_apb_regbank
    import rot_apb_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int ADDR_W      = 12,
    parameter int WAIT_STATES = 0
) (
    input  logic                 I_PCLK,
    input  logic                 I_PRESET,
    input  logic                 I_PSEL,
    input  logic                 I_PENABLE,
    input  logic                 I_PWRITE,
    input  logic [ADDR_W-1:0]    I_PADDR,
    input  logic [31:0]          I_PWDATA,
    input  logic [3:0]           I_PSTRB,
    output logic [31:0]          O_PRDATA,
    output logic                 O_PREADY,
    output logic                 O_PSLVERR,
    input  logic [NUM_CH-1:0]    I_CORE_BUSY,
    input  logic [NUM_CH-1:0]    I_CORE_DONE,
    input  logic [NUM_CH*16-1:0] I_ROT_IMG_NEW_H,
    input  logic [NUM_CH*16-1:0] I_ROT_IMG_NEW_W,
    output logic [NUM_CH*32-1:0] O_DMA_SRC_IMG,
    output logic [NUM_CH*32-1:0] O_DMA_DST_IMG,
    output logic [NUM_CH*16-1:0] O_ROT_IMG_H,
    output logic [NUM_CH*16-1:0] O_ROT_IMG_W,
    output logic [NUM_CH*2-1:0]  O_ROT_IMG_MODE,
    output logic [NUM_CH-1:0]    O_ROT_IMG_DIR,
    output logic [NUM_CH-1:0]    O_CTRL_START,
    output logic [NUM_CH-1:0]    O_CTRL_RESET,
    output logic                 O_INTR
);

    localparam int c_CH_W = ADDR_W - 5;

    logic [1:0]        r_wcnt_q;
    logic [1:0]        w_wcnt_d;
    logic              r_intr_q;
    logic              w_access;
    logic              w_ready;
    logic              w_ch_ok;
    logic              w_err;
    logic              w_sel_err;
    logic [31:0]       w_sel_rdata;
    logic              w_commit;
    logic [c_CH_W-1:0] w_ch;
    logic [2:0]        w_off;
    logic [31:0]       w_chan_rdata [NUM_CH];
    logic [NUM_CH-1:0] w_chan_err;
    logic [NUM_CH-1:0] w_done;
    logic [NUM_CH-1:0] w_mask;
    logic [1:0]        w_unused;

    assign w_access = I_PSEL & I_PENABLE;
    // Reset in flight forces PREADY low so an aborted write never commits.
    assign w_ready  = w_access & (r_wcnt_q == 2'(WAIT_STATES)) & ~I_PRESET;
    assign w_ch     = I_PADDR[ADDR_W-1:5];
    assign w_off    = I_PADDR[4:2];
    assign w_unused = I_PADDR[1:0];

    always_comb begin
        w_wcnt_d = r_wcnt_q;
        if (!w_access || w_ready)            w_wcnt_d = 2'd0;
        else if (r_wcnt_q < 2'(WAIT_STATES)) w_wcnt_d = r_wcnt_q + 2'd1;
    end

    always_ff @(posedge I_PCLK) begin
        if (I_PRESET) begin
            r_wcnt_q <= 2'd0;
            r_intr_q <= 1'b0;
        end else begin
            r_wcnt_q <= w_wcnt_d;
            r_intr_q <= |(w_done & ~w_mask);
        end
    end

    always_comb begin
        w_ch_ok     = 1'b0;
        w_sel_err   = 1'b0;
        w_sel_rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_ch == c_CH_W'(i)) begin
                w_ch_ok     = 1'b1;
                w_sel_err   = w_chan_err[i];
                w_sel_rdata = w_chan_rdata[i];
            end
        end
    end

    assign w_err     = ~w_ch_ok | w_sel_err;
    assign w_commit  = w_ready & I_PWRITE & ~w_err;
    assign O_PREADY  = w_ready;
    assign O_PSLVERR = w_ready & w_err;
    assign O_PRDATA  = (w_ready & ~w_err & ~I_PWRITE) ? w_sel_rdata : 32'd0;
    assign O_INTR    = r_intr_q;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            rot_apb_chan_regs u_chan (
                .clk     (I_PCLK),
                .rst     (I_PRESET),
                .i_wr    (w_commit & (w_ch == c_CH_W'(g))),
                .i_write (I_PWRITE),
                .i_off   (w_off),
                .i_wdata (I_PWDATA),
                .i_strb  (I_PSTRB),
                .i_busy  (I_CORE_BUSY[g]),
                .i_done  (I_CORE_DONE[g]),
                .i_new_h (I_ROT_IMG_NEW_H[16*g +: 16]),
                .i_new_w (I_ROT_IMG_NEW_W[16*g +: 16]),
                .o_rdata (w_chan_rdata[g]),
                .o_err   (w_chan_err[g]),
                .o_src   (O_DMA_SRC_IMG[32*g +: 32]),
                .o_dst   (O_DMA_DST_IMG[32*g +: 32]),
                .o_h     (O_ROT_IMG_H[16*g +: 16]),
                .o_w     (O_ROT_IMG_W[16*g +: 16]),
                .o_mode  (O_ROT_IMG_MODE[2*g +: 2]),
                .o_dir   (O_ROT_IMG_DIR[g]),
                .o_start (O_CTRL_START[g]),
                .o_reset (O_CTRL_RESET[g]),
                .o_done  (w_done[g]),
                .o_mask  (w_mask[g])
            );
        end
    endgenerate

endmodule
`default_nettype wire
